helios_stream_bridge: RTL
=========================

# helios_stream_bridge

Parametrised byte/word stream bridge for the Helios single-FPGA decoder: deserialises measurement rounds from an input stream of arbitrary word width into full-round vectors for the controller, and serialises per-round correction vectors back into output words. It sits between the external link and `unified_controller`. It replaces the fixed 8-bit packing with width-generic framing, round tracking, frame-end signalling and a synchronous flush.

## Interface
- `DATA_WIDTH`, 8: stream word width (≥1).
- `MEAS_WIDTH`, 12: measurement bits per round (PU count per round).
- `CORR_WIDTH`, 10: correction bits per round.
- `ROUNDS`, 3: rounds per frame (GRID_WIDTH_U).
- Derived: `IN_WORDS` = ceil(MEAS_WIDTH/DATA_WIDTH); `OUT_WORDS` = ceil(CORR_WIDTH/DATA_WIDTH); `RW` = max(1, clog2(ROUNDS)).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `flush` in 1: synchronous clear of ingress/egress progress.
- `in_data` in DATA_WIDTH: stream word.
- `in_valid` in 1 / `in_ready` out 1: ingress handshake.
- `meas_data` out MEAS_WIDTH: assembled round.
- `meas_valid` out 1 / `meas_ready` in 1: round handshake to controller.
- `round_index` out RW: index of the round presented on `meas_data`.
- `frame_done` out 1: one-cycle pulse when round ROUNDS-1 is accepted.
- `corr_data` in CORR_WIDTH / `corr_valid` in 1 / `corr_ready` out 1: correction handshake.
- `out_data` out DATA_WIDTH / `out_valid` out 1 / `out_ready` in 1: egress handshake.

## Operation
- A transfer occurs on a cycle where valid and ready are both 1 at the rising edge.
- Ingress FSM states are COLLECT and PRESENT.
  - COLLECT: `in_ready`=1. Word k (0-based) is written to `meas_data` bits [k*DATA_WIDTH +: DATA_WIDTH]. Bits ≥ MEAS_WIDTH in the last word are discarded. After word IN_WORDS-1 the FSM moves to PRESENT.
  - PRESENT: `in_ready`=0 and `meas_valid`=1. `meas_data` and `round_index` are held stable. On `meas_ready`, the FSM returns to COLLECT and the word counter goes to 0. `round_index` increments and wraps from ROUNDS-1 to 0. `frame_done` pulses on the following cycle if the accepted index was ROUNDS-1.
- Egress FSM states are IDLE and SEND.
  - IDLE: `corr_ready`=1. On `corr_valid`, `corr_data` is captured and the FSM enters SEND with word counter j=0.
  - SEND: `out_valid`=1. `out_data` = captured bits [j*DATA_WIDTH +: DATA_WIDTH], with bits at or above CORR_WIDTH driven 0. On `out_ready`, j increments. After word OUT_WORDS-1 the FSM returns to IDLE.
- Ingress and egress are fully independent and run concurrently.
- `flush`=1: both FSMs go to COLLECT/IDLE, all counters and `round_index` go to 0, and the partial assembly is discarded. A handshake in the same cycle is ignored. Flush takes priority over every other event.
- DATA_WIDTH ≥ MEAS_WIDTH gives IN_WORDS=1; DATA_WIDTH ≥ CORR_WIDTH gives OUT_WORDS=1. Both must work with no special casing.

## Timing
- Reset values: `in_ready`=1, `meas_valid`=0, `meas_data`=0, `round_index`=0, `frame_done`=0, `corr_ready`=1, `out_valid`=0, `out_data`=0.
- Ingress latency: the last input word transfer at edge N gives `meas_valid`=1 in cycle N+1.
- Egress latency: the correction transfer at edge N gives the first `out_valid` in cycle N+1.
- Ingress sustains 1 word/cycle. One bubble cycle follows each round; `in_ready` returns to 1 the cycle after `meas_ready` is accepted.
- Egress sustains 1 word/cycle. `corr_ready` returns to 1 the cycle after the last word is accepted.
- `out_valid` and `out_data` must not change while `out_valid`=1 and `out_ready`=0. The same holds for `meas_*` while stalled.
- Reset asserted mid-frame clears state immediately and asynchronously. Outputs show reset values until the first edge after release.

## Test plan
- DATA_WIDTH=8, MEAS_WIDTH=12, ROUNDS=3. Send words 0xAB, 0x0C; `meas_ready`=1 -> `meas_data`=0xCAB, `round_index`=0, `meas_valid` one cycle after the second word.
- Three rounds back-to-back -> `round_index` goes 0,1,2,0 and `frame_done` pulses exactly once, after round 2.
- CORR_WIDTH=10, `corr_data`=0x3FF, `out_ready` toggling 1,0,1 -> `out_data` is 0xFF, then 0x03 held during the stall, then `corr_ready`=1.
- DATA_WIDTH=32, MEAS_WIDTH=12. A single word 0xFFFFF123 -> `meas_data`=0x123.
- `flush` asserted after one of two words, with `in_valid` high that cycle -> counter reset, `round_index`=0, the next two words form a fresh round.
- `reset` pulled low while in SEND with `out_ready`=0 -> `out_valid`=0 immediately and `corr_ready`=1 after release.

Source files
------------

// File: rtl/helios_stream_bridge.sv
// helios_stream_bridge
// Width-generic stream bridge between the external link and the decoder
// controller. Ingress packs DATA_WIDTH-bit words into MEAS_WIDTH-bit rounds
// and tracks the round index within a frame. Egress unpacks CORR_WIDTH-bit
// correction vectors into DATA_WIDTH-bit words. Both sides are independent.
//
// Ports:
//   clk, reset (async, active-low), flush (sync clear)
//   in_data/in_valid/in_ready          : ingress word stream
//   meas_data/meas_valid/meas_ready    : assembled round to controller
//   round_index, frame_done            : round tracking within a frame
//   corr_data/corr_valid/corr_ready    : correction vector from controller
//   out_data/out_valid/out_ready       : egress word stream
module helios_stream_bridge #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEAS_WIDTH = 12,
  parameter int unsigned CORR_WIDTH = 10,
  parameter int unsigned ROUNDS     = 3,
  localparam int unsigned RW        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [MEAS_WIDTH-1:0] meas_data,
  output logic                  meas_valid,
  input  logic                  meas_ready,
  output logic [RW-1:0]         round_index,
  output logic                  frame_done,
  input  logic [CORR_WIDTH-1:0] corr_data,
  input  logic                  corr_valid,
  output logic                  corr_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned IN_WORDS  = (MEAS_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned OUT_WORDS = (CORR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned IN_BUF_W  = IN_WORDS * DATA_WIDTH;
  localparam int unsigned OUT_BUF_W = OUT_WORDS * DATA_WIDTH;
  localparam int unsigned ICW       = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
  localparam int unsigned OCW       = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  localparam logic [ICW-1:0] IN_LAST    = ICW'(IN_WORDS - 1);
  localparam logic [OCW-1:0] OUT_LAST   = OCW'(OUT_WORDS - 1);
  localparam logic [RW-1:0]  ROUND_LAST = RW'(ROUNDS - 1);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_SEND    = 1'b1;

  logic [0:0]           in_state_q, in_state_d;
  logic [ICW-1:0]       in_cnt_q, in_cnt_d;
  logic [IN_BUF_W-1:0]  in_buf_q, in_buf_d;
  logic [RW-1:0]        round_q, round_d;
  logic                 frame_done_q, frame_done_d;

  logic [0:0]           out_state_q, out_state_d;
  logic [OCW-1:0]       out_cnt_q, out_cnt_d;
  logic [OUT_BUF_W-1:0] out_buf_q, out_buf_d;

  // Ingress next state. New words enter at the top and shift down, so after
  // IN_WORDS transfers word k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
  always_comb begin
    in_state_d   = in_state_q;
    in_cnt_d     = in_cnt_q;
    in_buf_d     = in_buf_q;
    round_d      = round_q;
    frame_done_d = 1'b0;
    if (flush) begin
      in_state_d = ST_COLLECT;
      in_cnt_d   = '0;
      in_buf_d   = '0;
      round_d    = '0;
    end else begin
      case (in_state_q)
        ST_COLLECT: begin
          if (in_valid) begin
            in_buf_d = IN_BUF_W'({in_data, in_buf_q} >> DATA_WIDTH);
            if (in_cnt_q == IN_LAST) begin
              in_cnt_d   = '0;
              in_state_d = ST_PRESENT;
            end else begin
              in_cnt_d = in_cnt_q + 1'b1;
            end
          end
        end
        ST_PRESENT: begin
          if (meas_ready) begin
            in_state_d   = ST_COLLECT;
            in_cnt_d     = '0;
            frame_done_d = (round_q == ROUND_LAST);
            round_d      = (round_q == ROUND_LAST) ? '0 : round_q + 1'b1;
          end
        end
        default: in_state_d = ST_COLLECT;
      endcase
    end
  end

  // Egress next state. The captured vector is zero-extended so padding bits
  // above CORR_WIDTH go out as 0; each accepted word shifts the next one down.
  always_comb begin
    out_state_d = out_state_q;
    out_cnt_d   = out_cnt_q;
    out_buf_d   = out_buf_q;
    if (flush) begin
      out_state_d = ST_IDLE;
      out_cnt_d   = '0;
      out_buf_d   = '0;
    end else begin
      case (out_state_q)
        ST_IDLE: begin
          if (corr_valid) begin
            out_buf_d   = OUT_BUF_W'(corr_data);
            out_cnt_d   = '0;
            out_state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            out_buf_d = out_buf_q >> DATA_WIDTH;
            if (out_cnt_q == OUT_LAST) begin
              out_cnt_d   = '0;
              out_state_d = ST_IDLE;
            end else begin
              out_cnt_d = out_cnt_q + 1'b1;
            end
          end
        end
        default: out_state_d = ST_IDLE;
      endcase
    end
  end

  // State registers for both directions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_state_q   <= ST_COLLECT;
      in_cnt_q     <= '0;
      in_buf_q     <= '0;
      round_q      <= '0;
      frame_done_q <= 1'b0;
      out_state_q  <= ST_IDLE;
      out_cnt_q    <= '0;
      out_buf_q    <= '0;
    end else begin
      in_state_q   <= in_state_d;
      in_cnt_q     <= in_cnt_d;
      in_buf_q     <= in_buf_d;
      round_q      <= round_d;
      frame_done_q <= frame_done_d;
      out_state_q  <= out_state_d;
      out_cnt_q    <= out_cnt_d;
      out_buf_q    <= out_buf_d;
    end
  end

  // Outputs are direct decodes of flop state.
  assign in_ready    = (in_state_q == ST_COLLECT);
  assign meas_valid  = (in_state_q == ST_PRESENT);
  assign meas_data   = in_buf_q[MEAS_WIDTH-1:0];
  assign round_index = round_q;
  assign frame_done  = frame_done_q;
  assign corr_ready  = (out_state_q == ST_IDLE);
  assign out_valid   = (out_state_q == ST_SEND);
  assign out_data    = out_buf_q[DATA_WIDTH-1:0];

endmodule
